// File: rtl/serial_word_tx_if.sv
// Parallel-load / 3-wire serial link bundle for serial_word_tx.
// master drives start/data_in and observes the link; slave is the transmitter.
interface serial_word_tx_if #(
  parameter int WIDTH = 24
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic             cs_n;
  logic             sclk;
  logic             sdata;

  modport master (
    output start, data_in,
    input  busy, done, cs_n, sclk, sdata
  );

  modport slave (
    input  start, data_in,
    output busy, done, cs_n, sclk, sdata
  );
endinterface

// File: rtl/serial_word_tx.sv
// Snapshot-and-shift transmitter: loads one word on start and clocks it out on cs_n/sclk/sdata.
// Bit order is MSB first unless SERIAL_TX_LSB_FIRST_EN is defined (then LSB first).
module serial_word_tx #(
  parameter int WIDTH   = 24,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  serial_word_tx_if.slave  tx_if
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               sdata_q, sdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               div_wrap;
  logic               first_bit;
  logic               next_bit;
  logic [WIDTH-1:0]   shift_next;

  assign div_wrap = (div_cnt_q == DIV_W'(CLK_DIV - 1));

`ifdef SERIAL_TX_LSB_FIRST_EN
  assign first_bit  = tx_if.data_in[0];
  assign next_bit   = shift_q[1];
  assign shift_next = shift_q >> 1;
`else
  assign first_bit  = tx_if.data_in[WIDTH-1];
  assign next_bit   = shift_q[WIDTH-2];
  assign shift_next = shift_q << 1;
`endif

  // All state and every output are registered here; reset aborts any frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_if.start) state_d = SHIFT;
      SHIFT:   if (div_wrap && sclk_q && (bit_cnt_q == '0)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_if.start) begin
          shift_d   = tx_if.data_in;
          sdata_d   = first_bit;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = BIT_W'(WIDTH - 1);
          div_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (div_wrap) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          // Data only moves on the falling toggle so it is stable across each rise.
          if (sclk_q && (bit_cnt_q != '0)) begin
            shift_d   = shift_next;
            sdata_d   = next_bit;
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      FINISH: begin
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        sdata_d = 1'b0;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign tx_if.busy  = busy_q;
  assign tx_if.done  = done_q;
  assign tx_if.cs_n  = cs_n_q;
  assign tx_if.sclk  = sclk_q;
  assign tx_if.sdata = sdata_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Randomised scoreboard bench for serial_word_tx: a 24-bit/div-4 instance and an 8-bit/div-1
// instance, with a frame-level timing model and a serial receiver that rebuilds each word.
module tb_serial_word_tx;

  localparam int W0 = 24, D0 = 4;
  localparam int W1 = 8,  D1 = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_word_tx_if #(.WIDTH(W0)) if0 ();
  serial_word_tx_if #(.WIDTH(W1)) if1 ();

  serial_word_tx #(.WIDTH(W0), .CLK_DIV(D0)) dut0 (.clk(clk), .reset(reset), .tx_if(if0.slave));
  serial_word_tx #(.WIDTH(W1), .CLK_DIV(D1)) dut1 (.clk(clk), .reset(reset), .tx_if(if1.slave));

  logic        st  [2];
  logic [23:0] dat [2];
  assign if0.start   = st[0];
  assign if0.data_in = dat[0];
  assign if1.start   = st[1];
  assign if1.data_in = dat[1][7:0];

  logic m_busy [2], m_done [2], m_cs_n [2], m_sclk [2], m_sdata [2];
  assign m_busy[0] = if0.busy;  assign m_busy[1] = if1.busy;
  assign m_done[0] = if0.done;  assign m_done[1] = if1.done;
  assign m_cs_n[0] = if0.cs_n;  assign m_cs_n[1] = if1.cs_n;
  assign m_sclk[0] = if0.sclk;  assign m_sclk[1] = if1.sclk;
  assign m_sdata[0] = if0.sdata; assign m_sdata[1] = if1.sdata;

  typedef struct {
    logic [23:0] word;
    longint      done_edge;
  } exp_t;

  exp_t   sb_q [2][$];
  longint edge_cnt = 0;
  longint next_ok [2];
  longint f_start [2];
  bit     f_valid [2];

  logic [23:0] rx_word [2];
  int          rx_cnt [2];
  logic        prev_sclk [2], prev_sdata [2];

  int checks = 0;
  int errors = 0;

  function automatic int width_of(int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic longint frame_len(int d);
    return (d == 0) ? longint'(2 * W0 * D0) : longint'(2 * W1 * D1);
  endfunction

  // Word as it appears on the wire, first transmitted bit in position width-1.
  function automatic logic [23:0] wire_order(int d, logic [23:0] v);
    logic [23:0] r;
    int w;
    w = width_of(d);
    r = '0;
    for (int i = 0; i < w; i++) begin
`ifdef SERIAL_TX_LSB_FIRST_EN
      r[w-1-i] = v[i];
`else
      r[i] = v[i];
`endif
    end
    return r;
  endfunction

  function automatic void chk(string name, int d, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", name, d, edge_cnt, act, exp);
    end
  endfunction

  function automatic void flush_model();
    for (int d = 0; d < 2; d++) begin
      sb_q[d].delete();
      next_ok[d]    = 0;
      f_valid[d]    = 1'b0;
      f_start[d]    = 0;
      rx_word[d]    = '0;
      rx_cnt[d]     = 0;
      prev_sclk[d]  = 1'b0;
      prev_sdata[d] = 1'b0;
    end
  endfunction

  // Reference model: a start is taken only once the previous frame has fully ended.
  always @(posedge clk) begin
    exp_t e;
    edge_cnt = edge_cnt + 1;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (st[d] && edge_cnt >= next_ok[d]) begin
          e.word      = wire_order(d, (d == 0) ? dat[d] : {16'h0, dat[d][7:0]});
          e.done_edge = edge_cnt + frame_len(d) + 1;
          sb_q[d].push_back(e);
          f_start[d]  = edge_cnt;
          f_valid[d]  = 1'b1;
          next_ok[d]  = edge_cnt + frame_len(d) + 2;
        end
      end
    end
  end

  // Monitor: link receiver plus per-cycle framing checks; pops the scoreboard on done.
  always @(negedge clk) begin
    exp_t e;
    logic exp_b;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        exp_b = f_valid[d] && (edge_cnt >= f_start[d]) && (edge_cnt <= f_start[d] + frame_len(d));
        chk("busy", d, m_busy[d], exp_b);
        chk("cs_n", d, m_cs_n[d], !exp_b);
        chk("sclk_idle", d, m_sclk[d] & m_cs_n[d], 1'b0);
        if (prev_sclk[d] && m_sclk[d])
          chk("sdata_stable", d, m_sdata[d], prev_sdata[d]);
        if (m_sclk[d] && !prev_sclk[d]) begin
          rx_word[d] = {rx_word[d][22:0], m_sdata[d]};
          rx_cnt[d]  = rx_cnt[d] + 1;
        end
        if (m_done[d]) begin
          if (sb_q[d].size() == 0) begin
            chk("unexpected_done", d, 1'b1, 1'b0);
          end else begin
            e = sb_q[d].pop_front();
            chk("done_time", d, edge_cnt, e.done_edge);
            chk("bit_count", d, rx_cnt[d], width_of(d));
            chk("word", d, rx_word[d], e.word);
            $display("frame dut%0d: received %0h expected %0h at edge %0d", d, rx_word[d], e.word, edge_cnt);
          end
          rx_word[d] = '0;
          rx_cnt[d]  = 0;
        end
        prev_sclk[d]  = m_sclk[d];
        prev_sdata[d] = m_sdata[d];
      end
    end
  end

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, m_busy[d], 1'b0);
      chk("rst_done", d, m_done[d], 1'b0);
      chk("rst_cs_n", d, m_cs_n[d], 1'b1);
      chk("rst_sclk", d, m_sclk[d], 1'b0);
      chk("rst_sdata", d, m_sdata[d], 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    flush_model();
    #1;
    check_reset_outputs();
    $display("reset asserted at edge %0d", edge_cnt);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic pulse(int d, logic [23:0] v);
    @(negedge clk);
    st[d]  = 1'b1;
    dat[d] = v;
    @(negedge clk);
    st[d]  = 1'b0;
  endtask

  task automatic wait_idle(int d);
    int n;
    n = 0;
    while (edge_cnt < next_ok[d] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", d, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    st[0] = 1'b0; st[1] = 1'b0;
    dat[0] = '0;  dat[1] = '0;
    flush_model();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    #2;
    reset = 1'b0;

    // Reference words on both instances.
    pulse(0, 24'hA5C3F0);
    pulse(1, 24'h000081);
    wait_idle(0);
    wait_idle(1);

    // Re-pulsed start mid-frame must be ignored.
    pulse(0, 24'h123456);
    repeat (8) @(negedge clk);
    pulse(0, 24'hDEAD01);
    repeat (88) @(negedge clk);
    pulse(0, 24'h0BEEF0);
    wait_idle(0);

    // Reset mid-frame, then a clean frame.
    pulse(0, 24'h3C3C3C);
    pulse(1, 24'h00005A);
    repeat (47) @(negedge clk);
    do_reset();
    pulse(0, 24'hC0FFEE);
    pulse(1, 24'h0000E7);
    wait_idle(0);
    wait_idle(1);

    // Start held high: back-to-back frames, data changing after capture.
    @(negedge clk);
    st[0]  = 1'b1;
    dat[0] = 24'h000001;
    @(negedge clk);
    dat[0] = 24'hFFFFFF;
    repeat (250) @(negedge clk);
    st[0] = 1'b0;
    wait_idle(0);

    // Random starts and data churn on both instances.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        st[d]  = ($urandom_range(0, 99) < 4);
        dat[d] = 24'($urandom);
      end
    end
    @(negedge clk);
    st[0] = 1'b0;
    st[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);

    n = 0;
    while ((sb_q[0].size() != 0 || sb_q[1].size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("missing_done", 0, sb_q[0].size(), 0);
    chk("missing_done", 1, sb_q[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
